// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN layer memory path: widths, transfer direction
// and the image memory server state encoding.
package cnn_pkg;

  localparam int DATA_SIZE = 16;
  localparam int N         = 32;

  typedef enum logic {
    MEM_WRITE = 1'b0,
    MEM_READ  = 1'b1
  } mem_rw_e;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    TAIL,
    DONE,
    WAIT_LOW
  } mem_srv_state_e;

endpackage

// File: rtl/img_buffer.sv
// True dual-port image buffer with registered reads on both ports.
// Port A belongs to the transfer engine, port B to the layer.
module img_buffer #(
  parameter int DW    = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata
);

  logic [DW-1:0] mem [DEPTH];

  // The two write enables are never active together, so no collision rule is needed.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    if (b_we) mem[b_addr] <= b_wdata;
    a_rdata <= mem[a_addr];
    b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/img_mem_server.sv
// Moves an img_size x img_size image between the shared RAM and the local
// image buffer, one word per cycle, and pulses op_done when finished.
module img_mem_server #(
  parameter int DATA_SIZE = cnn_pkg::DATA_SIZE,
  parameter int N         = cnn_pkg::N,
  parameter int ADDR_W    = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_en,
  input  logic                        req_rw,
  input  logic [DATA_SIZE-1:0]        req_addr,
  input  logic [DATA_SIZE-1:0]        img_size,
  output logic                        op_done,
  output logic                        busy,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic                        ram_we,
  output logic [DATA_SIZE-1:0]        ram_wdata,
  input  logic [DATA_SIZE-1:0]        ram_rdata,
  input  logic [$clog2(N*N)-1:0]      lyr_addr,
  input  logic                        lyr_we,
  input  logic [DATA_SIZE-1:0]        lyr_wdata,
  output logic [DATA_SIZE-1:0]        lyr_rdata
);

  import cnn_pkg::*;

  localparam int AW = $clog2(N*N);
  localparam int LW = 2 * DATA_SIZE;

  mem_srv_state_e       state, next_state;
  mem_rw_e              rw_q;
  logic [LW-1:0]        k_q, len_q, len_in;
  logic [ADDR_W-1:0]    base_q, addr_k;
  logic [DATA_SIZE-1:0] side, a_rdata;
  logic [AW-1:0]        wr_idx, a_addr;
  logic                 wr_pend, last_k, b_we;

  assign side    = (img_size > DATA_SIZE'(N)) ? DATA_SIZE'(N) : img_size;
  assign len_in  = LW'(side) * LW'(side);
  assign last_k  = (k_q == len_q - LW'(1));
  assign addr_k  = base_q + k_q[ADDR_W-1:0];

  assign busy    = state inside {STREAM, TAIL, DONE};
  assign op_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (req_en) next_state = (len_in == '0) ? DONE : STREAM;
      STREAM:   if (last_k) next_state = TAIL;
      TAIL:     next_state = DONE;
      DONE:     next_state = req_en ? WAIT_LOW : IDLE;
      WAIT_LOW: if (!req_en) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Reads present address k and capture the returned word one cycle later;
  // writes fetch buffer word k and strobe it to RAM one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      k_q      <= '0;
      len_q    <= '0;
      base_q   <= '0;
      rw_q     <= MEM_WRITE;
      wr_pend  <= 1'b0;
      wr_idx   <= '0;
      ram_addr <= '0;
      ram_we   <= 1'b0;
    end else begin
      wr_pend <= 1'b0;
      ram_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_en) begin
            k_q    <= '0;
            len_q  <= len_in;
            base_q <= ADDR_W'(req_addr);
            rw_q   <= mem_rw_e'(req_rw);
            if (req_rw && (len_in != '0)) ram_addr <= ADDR_W'(req_addr);
          end
        end
        STREAM: begin
          k_q <= k_q + LW'(1);
          if (rw_q == MEM_READ) begin
            wr_pend <= 1'b1;
            wr_idx  <= k_q[AW-1:0];
            if (!last_k) ram_addr <= addr_k + ADDR_W'(1);
          end else begin
            ram_we   <= 1'b1;
            ram_addr <= addr_k;
          end
        end
        default: ;
      endcase
    end
  end

  assign a_addr    = wr_pend ? wr_idx : k_q[AW-1:0];
  assign ram_wdata = ram_we ? a_rdata : '0;
  assign b_we      = lyr_we & ~busy;

  img_buffer #(
    .DW    (DATA_SIZE),
    .DEPTH (N*N),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .a_we    (wr_pend),
    .a_addr  (a_addr),
    .a_wdata (ram_rdata),
    .a_rdata (a_rdata),
    .b_we    (b_we),
    .b_addr  (lyr_addr),
    .b_wdata (lyr_wdata),
    .b_rdata (lyr_rdata)
  );

endmodule

// File: tb/tb_img_mem_server.sv
// Directed bench for img_mem_server; the RAM model returns addr ^ 16'h5A5A
// one cycle after the address is presented.
module tb_img_mem_server;

  localparam int BW = $clog2(32*32);

  logic          clk = 1'b0;
  logic          reset, req_en, req_rw;
  logic [15:0]   req_addr, img_size;
  logic          op_done, busy, ram_we, lyr_we;
  logic [15:0]   ram_addr, ram_wdata, ram_rdata, lyr_wdata, lyr_rdata;
  logic [BW-1:0] lyr_addr;

  int total = 0;
  int bad   = 0;
  int done_cycle, we_count;

  logic [15:0] log_addr [0:1199];
  logic        log_we   [0:1199];
  logic [15:0] log_wd   [0:1199];

  img_mem_server dut (
    .clk       (clk),
    .reset     (reset),
    .req_en    (req_en),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .img_size  (img_size),
    .op_done   (op_done),
    .busy      (busy),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .lyr_addr  (lyr_addr),
    .lyr_we    (lyr_we),
    .lyr_wdata (lyr_wdata),
    .lyr_rdata (lyr_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_rdata <= ram_addr ^ 16'h5A5A;

  // Issues one request and logs RAM-side activity per cycle, index 0 = c0.
  task automatic run_request(input logic rw, input logic [15:0] addr, input logic [15:0] size,
                             input int max_cycles, input bit drop, input bit poke);
    done_cycle = -1;
    we_count   = 0;
    @(negedge clk);
    req_en = 1'b1; req_rw = rw; req_addr = addr; img_size = size;
    for (int c = 0; c < max_cycles; c++) begin
      @(negedge clk);
      log_addr[c] = ram_addr;
      log_we[c]   = ram_we;
      log_wd[c]   = ram_wdata;
      if (ram_we) we_count++;
      if (c == 0) begin
        req_rw = ~rw; req_addr = ~addr; img_size = 16'd7;
        if (poke) begin lyr_we = 1'b1; lyr_addr = '0; lyr_wdata = 16'hFFFF; end
      end
      if (op_done) begin
        done_cycle = c;
        lyr_we = 1'b0;
        if (drop) req_en = 1'b0;
        break;
      end
    end
    if (done_cycle < 0) begin req_en = 1'b0; lyr_we = 1'b0; end
  endtask

  task automatic read_buf(input int idx, output logic [15:0] val);
    @(negedge clk);
    lyr_addr = BW'(idx);
    @(negedge clk);
    val = lyr_rdata;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (op_done !== 1'b0)    begin bad++; $display("FAIL reset_op_done got=%b want=0", op_done); end
    total++; if (ram_we !== 1'b0)     begin bad++; $display("FAIL reset_ram_we got=%b want=0", ram_we); end
    total++; if (ram_addr !== 16'h0)  begin bad++; $display("FAIL reset_ram_addr got=%h want=0000", ram_addr); end
    total++; if (ram_wdata !== 16'h0) begin bad++; $display("FAIL reset_ram_wdata got=%h want=0000", ram_wdata); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_2x2();
    logic [15:0] v;
    run_request(1'b1, 16'd100, 16'd2, 20, 1'b1, 1'b1);
    total++; if (done_cycle != 5) begin bad++; $display("FAIL rd2_done_cycle got=%0d want=5", done_cycle); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (log_addr[i] !== 16'(100 + i)) begin bad++; $display("FAIL rd2_addr[%0d] got=%h want=%h", i, log_addr[i], 16'(100 + i)); end
    end
    total++; if (we_count != 0) begin bad++; $display("FAIL rd2_we_count got=%0d want=0", we_count); end
    @(negedge clk);
    total++; if (op_done !== 1'b0) begin bad++; $display("FAIL rd2_single_pulse got=%b want=0", op_done); end
    for (int i = 0; i < 4; i++) begin
      read_buf(i, v);
      total++;
      if (v !== (16'(100 + i) ^ 16'h5A5A)) begin bad++; $display("FAIL rd2_buf[%0d] got=%h want=%h", i, v, 16'(100 + i) ^ 16'h5A5A); end
    end
  endtask

  task automatic test_write_3x3();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      lyr_we = 1'b1; lyr_addr = BW'(i); lyr_wdata = 16'hA000 + 16'(i * 16'h0111);
    end
    @(negedge clk);
    lyr_we = 1'b0;
    run_request(1'b0, 16'd0, 16'd3, 30, 1'b1, 1'b0);
    total++; if (done_cycle != 10) begin bad++; $display("FAIL wr3_done_cycle got=%0d want=10", done_cycle); end
    total++; if (we_count != 9)    begin bad++; $display("FAIL wr3_we_count got=%0d want=9", we_count); end
    total++; if (log_we[0] !== 1'b0) begin bad++; $display("FAIL wr3_we_c0 got=%b want=0", log_we[0]); end
    for (int c = 1; c <= 9; c++) begin
      total++; if (log_we[c] !== 1'b1) begin bad++; $display("FAIL wr3_we[%0d] got=%b want=1", c, log_we[c]); end
      total++; if (log_addr[c] !== 16'(c - 1)) begin bad++; $display("FAIL wr3_addr[%0d] got=%h want=%h", c, log_addr[c], 16'(c - 1)); end
      total++;
      if (log_wd[c] !== (16'hA000 + 16'((c - 1) * 16'h0111))) begin
        bad++; $display("FAIL wr3_data[%0d] got=%h want=%h", c, log_wd[c], 16'hA000 + 16'((c - 1) * 16'h0111));
      end
    end
  endtask

  task automatic test_zero_size();
    run_request(1'b1, 16'h4444, 16'd0, 10, 1'b1, 1'b0);
    total++; if (done_cycle != 0)       begin bad++; $display("FAIL zero_done_cycle got=%0d want=0", done_cycle); end
    total++; if (log_we[0] !== 1'b0)    begin bad++; $display("FAIL zero_we got=%b want=0", log_we[0]); end
    total++; if (log_addr[0] !== 16'd8) begin bad++; $display("FAIL zero_addr got=%h want=0008", log_addr[0]); end
    @(negedge clk);
    total++; if (busy !== 1'b0)         begin bad++; $display("FAIL zero_busy_after got=%b want=0", busy); end
    total++; if (ram_addr !== 16'd8)    begin bad++; $display("FAIL zero_addr_after got=%h want=0008", ram_addr); end
  endtask

  task automatic test_clamp_40();
    logic [15:0] v;
    int idx [3] = '{0, 517, 1023};
    run_request(1'b1, 16'h1000, 16'd40, 1100, 1'b1, 1'b0);
    total++; if (done_cycle != 1025)        begin bad++; $display("FAIL big_done_cycle got=%0d want=1025", done_cycle); end
    total++; if (we_count != 0)             begin bad++; $display("FAIL big_we_count got=%0d want=0", we_count); end
    total++; if (log_addr[0] !== 16'h1000)  begin bad++; $display("FAIL big_first_addr got=%h want=1000", log_addr[0]); end
    total++; if (log_addr[1023] !== 16'h13FF) begin bad++; $display("FAIL big_last_addr got=%h want=13ff", log_addr[1023]); end
    total++; if (log_addr[1024] !== 16'h13FF) begin bad++; $display("FAIL big_tail_addr got=%h want=13ff", log_addr[1024]); end
    for (int i = 0; i < 3; i++) begin
      read_buf(idx[i], v);
      total++;
      if (v !== (16'(16'h1000 + idx[i]) ^ 16'h5A5A)) begin
        bad++; $display("FAIL big_buf[%0d] got=%h want=%h", idx[i], v, 16'(16'h1000 + idx[i]) ^ 16'h5A5A);
      end
    end
  endtask

  task automatic test_addr_wrap();
    logic [15:0] v;
    logic [15:0] exp_addr [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    run_request(1'b1, 16'hFFFE, 16'd2, 20, 1'b1, 1'b0);
    total++; if (done_cycle != 5) begin bad++; $display("FAIL wrap_done_cycle got=%0d want=5", done_cycle); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (log_addr[i] !== exp_addr[i]) begin bad++; $display("FAIL wrap_addr[%0d] got=%h want=%h", i, log_addr[i], exp_addr[i]); end
    end
    read_buf(2, v);
    total++; if (v !== 16'h5A5A) begin bad++; $display("FAIL wrap_buf[2] got=%h want=5a5a", v); end
  endtask

  task automatic test_held_request();
    logic [15:0] v;
    run_request(1'b1, 16'h0020, 16'd1, 20, 1'b0, 1'b0);
    total++; if (done_cycle != 2) begin bad++; $display("FAIL held_done_cycle got=%0d want=2", done_cycle); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (op_done !== 1'b0) begin bad++; $display("FAIL held_op_done[%0d] got=%b want=0", i, op_done); end
      total++; if (busy !== 1'b0)    begin bad++; $display("FAIL held_busy[%0d] got=%b want=0", i, busy); end
    end
    req_en = 1'b0;
    @(negedge clk);
    run_request(1'b1, 16'h0030, 16'd1, 20, 1'b1, 1'b0);
    total++; if (done_cycle != 2) begin bad++; $display("FAIL held_second_done got=%0d want=2", done_cycle); end
    read_buf(0, v);
    total++; if (v !== (16'h0030 ^ 16'h5A5A)) begin bad++; $display("FAIL held_second_buf got=%h want=%h", v, 16'h0030 ^ 16'h5A5A); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    int seen;
    @(negedge clk);
    req_en = 1'b1; req_rw = 1'b1; req_addr = 16'h0200; img_size = 16'd4;
    for (int c = 0; c < 4; c++) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_k3 got=%b want=1", busy); end
    reset = 1'b1; req_en = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL mid_busy_after got=%b want=0", busy); end
    total++; if (ram_we !== 1'b0)  begin bad++; $display("FAIL mid_we_after got=%b want=0", ram_we); end
    total++; if (op_done !== 1'b0) begin bad++; $display("FAIL mid_done_after got=%b want=0", op_done); end
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (op_done || ram_we) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL mid_late_activity got=%0d want=0", seen); end
    run_request(1'b1, 16'h0300, 16'd1, 20, 1'b1, 1'b0);
    total++; if (done_cycle != 2) begin bad++; $display("FAIL mid_next_done got=%0d want=2", done_cycle); end
    read_buf(0, v);
    total++; if (v !== (16'h0300 ^ 16'h5A5A)) begin bad++; $display("FAIL mid_next_buf got=%h want=%h", v, 16'h0300 ^ 16'h5A5A); end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; req_en = 1'b0; req_rw = 1'b0; req_addr = '0; img_size = '0;
    lyr_addr = '0; lyr_we = 1'b0; lyr_wdata = '0;
    test_reset();
    test_read_2x2();
    test_write_3x3();
    test_zero_size();
    test_clamp_40();
    test_addr_wrap();
    test_held_request();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/img_mem_server.md
# img_mem_server

Memory-side responder for the CNN layer image-load/store handshake. It accepts a request from a layer (conv or pool) and moves an `img_size`×`img_size` image between the word-addressed intermediate RAM and a local image buffer, one word per cycle. It signals completion with a one-cycle `op_done` pulse. It sits between the layers' `loadImgEnable`/`loadImgAddrr`/`RW`/`opDone` handshake and the shared RAM.

## Interface
- `DATA_SIZE`, 16: pixel/word width and width of the address/size inputs.
- `N`, 32: maximum image side; the buffer holds N*N words.
- `ADDR_W`, 16: RAM address width.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_en` in 1: request level, held by the layer until it sees `op_done`.
- `req_rw` in 1: 1 = read (RAM→buffer), 0 = write (buffer→RAM).
- `req_addr` in DATA_SIZE: base RAM word address.
- `img_size` in DATA_SIZE: image side.
- `op_done` out 1: one-cycle completion pulse.
- `busy` out 1: transfer in progress.
- `ram_addr` out ADDR_W: RAM word address.
- `ram_we` out 1: RAM write strobe.
- `ram_wdata` out DATA_SIZE: RAM write data.
- `ram_rdata` in DATA_SIZE: RAM read data, valid 1 cycle after `ram_addr`.
- `lyr_addr` in $clog2(N*N): layer-side buffer address.
- `lyr_we` in 1: layer-side buffer write.
- `lyr_wdata` in DATA_SIZE: layer-side buffer write data.
- `lyr_rdata` out DATA_SIZE: layer-side buffer read data, 1-cycle latency.

## Operation
- **Reset values:** `op_done`=0, `busy`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0. State = IDLE, counter = 0.
- **Sizing:**
  - S = min(`img_size`, N).
  - L = S*S, computed in 2*DATA_SIZE bits.
  - `req_rw`, `req_addr` and S are latched at accept; later input changes are ignored.
- **FSM states:** IDLE, STREAM, TAIL, DONE, WAIT_LOW.
  - IDLE → STREAM when `req_en`=1 and L>0.
  - IDLE → DONE when `req_en`=1 and L=0. No RAM access occurs in this case.
  - STREAM: counter k runs 0..L-1, one per cycle. Go to TAIL after k=L-1.
  - TAIL: one cycle that completes the pipelined last word.
  - DONE: `op_done`=1 for this cycle only. Go to IDLE if `req_en`=0, else WAIT_LOW.
  - WAIT_LOW: stay until `req_en`=0, then IDLE. This prevents servicing a held request twice.
- **Read (`req_rw`=1):**
  - In STREAM cycle k: `ram_addr` = base+k, `ram_we`=0.
  - `ram_rdata` from the following cycle is written to buffer word k. The write for k=L-1 happens in TAIL.
- **Write (`req_rw`=0):**
  - In STREAM cycle k: buffer port A reads word k.
  - In the next cycle: `ram_we`=1, `ram_addr` = base+k, `ram_wdata` = that buffer word.
- **Address arithmetic:** `ram_addr` = (base+k) mod 2^ADDR_W, wrapping silently.
- **`busy`:** 1 in STREAM, TAIL and DONE; 0 in IDLE and WAIT_LOW.
- **Layer port:**
  - `lyr_we` is honoured only when `busy`=0 and ignored otherwise.
  - `lyr_rdata` is always driven: buffer port B, 1-cycle latency.
- **Reset mid-transfer:** aborts immediately, with no `op_done` and no further RAM strobes. Buffer contents are undefined.

## Timing
- Accept at edge E (IDLE, `req_en`=1). Cycle c0 is the first cycle after E.
- First RAM access:
  - Read: `ram_addr`=base in c0.
  - Write: first `ram_we` in c0+1.
- The last buffer write (read) or RAM write (write) happens in cycle c0+L.
- `op_done` is high in cycle c0+L+1. Total: L+2 cycles from accept edge to the `op_done` cycle.
- L=0: `op_done` in c0.
- Back-to-back requests: the earliest re-accept is the edge after the first cycle in IDLE with `req_en`=1. The layer must drop `req_en` for ≥1 cycle after `op_done`.

## Structure
- **Shared package `cnn_pkg`:**
  - `DATA_SIZE`, `N`.
  - `mem_rw_e` (`MEM_WRITE`=0, `MEM_READ`=1).
  - State enum `mem_srv_state_e`.
- **Sub-module `img_buffer`:** true dual-port N*N×DATA_SIZE RAM with 1-cycle read on both ports.
  - Port A is the FSM side; port B is the layer side.
  - Same-address simultaneous writes cannot occur, because `lyr_we` is gated by `busy`.

## Test plan
- **Read 2×2:** `req_addr`=100, RAM[100..103]={5,6,7,8} → `ram_addr` 100..103 in c0..c0+3; buffer words 0..3 = 5,6,7,8 (checked via `lyr_rdata`); `op_done` exactly in c0+5.
- **Write 3×3:** preload buffer 0..8 via `lyr_we`, `req_addr`=0 → nine `ram_we` pulses in c0+1..c0+9 with matching addresses and data; `op_done` in c0+10.
- **`img_size`=0** → no `ram_we`, no `ram_addr` change, `op_done` in c0. **`img_size`=40** → exactly 1024 words transferred.
- **Address wrap:** `req_addr`=0xFFFE, read 2×2 → `ram_addr` sequence FFFE, FFFF, 0000, 0001.
- **Held request:** `req_en` held high 5 cycles past `op_done` → single transfer, FSM in WAIT_LOW. Drop then re-raise `req_en` → second transfer accepted.
- **Reset mid-transfer:** `reset` at k=3 of a 4×4 read → next cycle `busy`=0, `ram_we`=0; `op_done` never pulses. A following 1×1 read completes normally.
